knight_cmd_seq: RTL and testbench

Hardware command sequencer for the Knight's Tour command path. It queues calibrate and move requests, encodes each into the 16-bit command word, and issues them one at a time with a single-cycle `send_cmd` strobe. After each issue it waits for a completion edge, with a per-command timeout. It sits between the tour-solver/host side and the command interface of the knight controller, replacing hand-sequenced command issue.

---
 rtl/knight_pkg.sv | 36 +++
 rtl/knight_cmd_seq_fifo.sv | 46 ++++
 rtl/knight_cmd_seq.sv | 110 +++++++++++
 tb/tb_knight_cmd_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knight_pkg.sv
// Shared types and command-word encoding for the Knight's Tour command path.
// Pure definitions, no latency; no flow control of its own.
package knight_pkg;

  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_CAL  = 3'b000;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  typedef enum logic [1:0] {DIR_N = 2'd0, DIR_W = 2'd1, DIR_S = 2'd2, DIR_E = 2'd3} dir_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} seq_state_t;

  typedef struct packed {
    logic       cal;
    logic       fanfare;
    dir_t       dir;
    logic [3:0] sqrs;
  } entry_t;

  function automatic logic [15:0] encode(entry_t e);
    logic [7:0] hd;
    case (e.dir)
      DIR_N:   hd = HEAD_N;
      DIR_W:   hd = HEAD_W;
      DIR_S:   hd = HEAD_S;
      default: hd = HEAD_E;
    endcase
    if (e.cal) encode = {OP_CAL, 13'd0};
    else       encode = {OP_MOVE, e.fanfare, hd, e.sqrs};
  endfunction

endpackage

// File: rtl/knight_cmd_seq_fifo.sv
// Command-entry queue: push/pop take effect on the next edge, flush clears it.
// Caller must gate push on !full and pop on !empty; flush overrides both.
module cmd_fifo
  import knight_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  entry_t                   din,
  output entry_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Extra wrap bit makes the pointer difference the exact occupancy.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/knight_cmd_seq.sv
// Queues calibrate/move requests and issues them one at a time with a send_cmd strobe.
// start->send_cmd 1 cycle, done edge->next send 1 cycle; full queue or ERR rejects enqueues via rej.
module knight_cmd_seq
  import knight_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int TIMEOUT_CLKS = 1_000_000,
  parameter int MAX_SQ       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  logic                     enq_cal,
  input  logic                     enq_fanfare,
  input  logic [1:0]               enq_dir,
  input  logic [3:0]               enq_sqrs,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     clr_err,
  input  logic                     cmd_done,
  output logic [15:0]              cmd,
  output logic                     send_cmd,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     rej,
  output logic                     timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [TW-1:0] timer;
  logic          cmd_done_q;
  logic          done_edge;
  logic          abort_act;
  logic          timed_out;
  logic          flush;
  logic          legal;
  logic          accept;
  entry_t        din;
  entry_t        head;

  assign done_edge = cmd_done & ~cmd_done_q;
  assign abort_act = abort && (state != ERR);
  assign timed_out = (state == WAIT) && !done_edge && (timer == TW'(TIMEOUT_CLKS - 1));
  assign flush     = abort_act || timed_out;
  assign legal     = enq_cal || ((enq_sqrs != 4'd0) && (enq_sqrs <= 4'(MAX_SQ)));
  assign accept    = enq && !full && legal && (state != ERR) && !flush;
  assign din       = '{cal: enq_cal, fanfare: enq_fanfare, dir: dir_t'(enq_dir), sqrs: enq_sqrs};

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (state == ISSUE),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_act) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !empty) state_nxt = ISSUE;
        ISSUE:   state_nxt = WAIT;
        WAIT: begin
          // Completion beats timeout when both land on the same cycle.
          if (done_edge)      state_nxt = empty ? IDLE : ISSUE;
          else if (timed_out) state_nxt = ERR;
        end
        ERR:     if (clr_err) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd        <= 16'h0000;
      timer      <= '0;
      cmd_done_q <= 1'b0;
      rej        <= 1'b0;
    end else begin
      cmd_done_q <= cmd_done;
      rej        <= enq && !accept;
      if (state_nxt == ISSUE) cmd <= encode(head);
      if (abort_act || state == ISSUE) timer <= '0;
      else if (state == WAIT)          timer <= timer + 1'b1;
    end
  end

  assign send_cmd    = (state == ISSUE);
  assign busy        = (state != IDLE);
  assign timeout_err = (state == ERR);

endmodule

// File: tb/tb_knight_cmd_seq.sv
// Bench for knight_cmd_seq: vector table, directed corner sequences, random run vs a queue model.
module tb_knight_cmd_seq;

  localparam int DEPTH = 4;
  localparam int TO    = 20;
  localparam int MAXSQ = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_WAIT  = 2;
  localparam int M_ERR   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, enq = 1'b0, enq_cal = 1'b0, enq_fanfare = 1'b0;
  logic [1:0]    enq_dir = 2'd0;
  logic [3:0]    enq_sqrs = 4'd0;
  logic          start = 1'b0, abort = 1'b0, clr_err = 1'b0, cmd_done = 1'b0;
  logic [15:0]   cmd;
  logic          send_cmd, full, empty, busy, rej, timeout_err;
  logic [CW-1:0] count;

  knight_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TO), .MAX_SQ(MAXSQ)) dut (
    .clk(clk), .rst(rst), .enq(enq), .enq_cal(enq_cal), .enq_fanfare(enq_fanfare),
    .enq_dir(enq_dir), .enq_sqrs(enq_sqrs), .start(start), .abort(abort),
    .clr_err(clr_err), .cmd_done(cmd_done), .cmd(cmd), .send_cmd(send_cmd),
    .full(full), .empty(empty), .count(count), .busy(busy), .rej(rej),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of already-encoded words plus the sequencer mode.
  logic [15:0] mq[$];
  int          m_mode = M_IDLE;
  int          m_waited = 0;
  logic        m_cdp = 1'b0;
  logic [15:0] m_cmd = 16'h0000;
  logic        m_rej = 1'b0;

  function automatic logic [15:0] ref_word(bit cal, bit ff, int d, int s);
    int hd;
    if (cal) return 16'h0000;
    case (d)
      0:       hd = 'h00;
      1:       hd = 'h3F;
      2:       hd = 'h7F;
      default: hd = 'hBF;
    endcase
    return 16'(8192 + ff * 4096 + hd * 16 + s);
  endfunction

  task automatic model_step();
    bit edge_seen, is_full, legal, flush, acc;
    if (rst) begin
      mq.delete();
      m_mode = M_IDLE; m_waited = 0; m_cdp = 1'b0; m_cmd = 16'h0000; m_rej = 1'b0;
      return;
    end
    edge_seen = cmd_done && !m_cdp;
    is_full   = (mq.size() == DEPTH);
    legal     = enq_cal || (enq_sqrs >= 1 && enq_sqrs <= MAXSQ);
    flush     = (abort && m_mode != M_ERR) ||
                (m_mode == M_WAIT && !edge_seen && m_waited == TO - 1);
    acc       = enq && !is_full && legal && m_mode != M_ERR && !flush;
    m_rej     = enq && !acc;
    if (abort && m_mode != M_ERR) begin
      mq.delete(); m_mode = M_IDLE; m_waited = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (start && mq.size() > 0) begin m_cmd = mq[0]; m_mode = M_ISSUE; end
        M_ISSUE: begin void'(mq.pop_front()); m_waited = 0; m_mode = M_WAIT; end
        M_WAIT: begin
          if (edge_seen) begin
            if (mq.size() > 0) begin m_cmd = mq[0]; m_mode = M_ISSUE; end
            else m_mode = M_IDLE;
          end else if (m_waited == TO - 1) begin
            mq.delete(); m_mode = M_ERR;
          end else m_waited++;
        end
        default: if (clr_err) m_mode = M_IDLE;
      endcase
    end
    if (acc) mq.push_back(ref_word(enq_cal, enq_fanfare, int'(enq_dir), int'(enq_sqrs)));
    m_cdp = cmd_done;
  endtask

  task automatic compare(string nm);
    logic [15:0]   e_cmd;
    logic [CW-1:0] e_cnt;
    logic [5:0]    e_flags, g_flags;
    e_cmd   = m_cmd;
    e_cnt   = CW'(mq.size());
    e_flags = {m_mode == M_ISSUE, mq.size() == DEPTH, mq.size() == 0,
               m_mode != M_IDLE, m_rej, m_mode == M_ERR};
    g_flags = {send_cmd, full, empty, busy, rej, timeout_err};
    total++;
    if (cmd !== e_cmd || count !== e_cnt || g_flags !== e_flags) begin
      bad++;
      $display("FAIL %s model: got cmd=%h cnt=%0d send/full/empty/busy/rej/terr=%b want cmd=%h cnt=%0d flags=%b",
               nm, cmd, count, g_flags, e_cmd, e_cnt, e_flags);
    end
  endtask

  task automatic cyc(string nm);
    model_step();
    @(posedge clk);
    #1;
    compare(nm);
    rst = 1'b0; enq = 1'b0; start = 1'b0; abort = 1'b0; clr_err = 1'b0;
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic push_entry(bit cal, bit ff, int d, int s);
    enq = 1'b1; enq_cal = cal; enq_fanfare = ff; enq_dir = 2'(d); enq_sqrs = 4'(s);
    cyc("push");
  endtask

  task automatic check_reset_outputs(string nm);
    chk({nm, "_cmd"}, 32'(cmd), 32'h0);
    chk({nm, "_flags"}, 32'({send_cmd, full, empty, busy, rej, timeout_err}), 32'b001000);
    chk({nm, "_count"}, 32'(count), 32'd0);
  endtask

  typedef struct {
    bit cal; bit ff; int d; int s;
    bit exp_rej; int exp_cnt;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{cal: 1, ff: 1, d: 3, s: 0, exp_rej: 0, exp_cnt: 1};
    vt[1] = '{cal: 0, ff: 0, d: 0, s: 0, exp_rej: 1, exp_cnt: 1};
    vt[2] = '{cal: 0, ff: 1, d: 0, s: 2, exp_rej: 0, exp_cnt: 2};
    vt[3] = '{cal: 0, ff: 0, d: 1, s: 3, exp_rej: 1, exp_cnt: 2};
    vt[4] = '{cal: 0, ff: 0, d: 2, s: 15, exp_rej: 1, exp_cnt: 2};
    vt[5] = '{cal: 0, ff: 0, d: 3, s: 1, exp_rej: 0, exp_cnt: 3};

    // Reset
    rst = 1'b1; cyc("reset0");
    rst = 1'b1; cyc("reset1");
    check_reset_outputs("reset");

    // Enqueue legality table
    for (int i = 0; i < 6; i++) begin
      push_entry(vt[i].cal, vt[i].ff, vt[i].d, vt[i].s);
      chk($sformatf("vec%0d_rej", i), 32'(rej), 32'(vt[i].exp_rej));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].exp_cnt));
    end

    // Drain cal, N2 fanfare, E1
    start = 1'b1; cyc("start");
    chk("run0_send", 32'(send_cmd), 32'd1);
    chk("run0_cmd", 32'(cmd), 32'h0000);
    cyc("run0_wait"); chk("run0_strobe_len", 32'(send_cmd), 32'd0);
    cyc("w"); cyc("w");
    cmd_done = 1'b1; cyc("edge1");
    chk("run1_send", 32'(send_cmd), 32'd1);
    chk("run1_cmd", 32'(cmd), 32'h3002);
    cyc("w"); chk("run1_strobe_len", 32'(send_cmd), 32'd0);
    cmd_done = 1'b0; cyc("w");
    cmd_done = 1'b1; cyc("edge2");
    chk("run2_send", 32'(send_cmd), 32'd1);
    chk("run2_cmd", 32'(cmd), 32'h2BF1);
    cyc("w");
    cmd_done = 1'b0; cyc("w");
    cmd_done = 1'b1; cyc("edge3");
    chk("run_end_idle", 32'({busy, empty, send_cmd}), 32'b010);
    chk("run_end_cmd_held", 32'(cmd), 32'h2BF1);
    cmd_done = 1'b0; cyc("w");

    // Fill past DEPTH
    for (int i = 0; i <= DEPTH; i++) begin
      push_entry(0, 0, 0, 1);
      chk($sformatf("fill%0d_rej", i), 32'(rej), 32'(i == DEPTH));
    end
    chk("fill_count", 32'(count), 32'(DEPTH));
    chk("fill_full", 32'(full), 32'd1);

    // Enqueue while full and popping: still dropped
    start = 1'b1; enq = 1'b1; enq_sqrs = 4'd1; cyc("start_full");
    chk("start_full_rej", 32'(rej), 32'd1);
    enq = 1'b1; cyc("pop_full");
    chk("pop_full_rej", 32'(rej), 32'd1);
    chk("pop_full_count", 32'(count), 32'(DEPTH - 1));

    // Timeout: WAIT now visible; ERR exactly TO cycles later
    for (int k = 1; k <= TO; k++) begin
      cyc("to");
      if (k == TO - 1) chk("to_early", 32'(timeout_err), 32'd0);
    end
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_flush", 32'(count), 32'd0);
    push_entry(1, 0, 0, 0);
    chk("err_rej", 32'(rej), 32'd1);
    clr_err = 1'b1; cyc("clr");
    chk("clr_idle", 32'({busy, timeout_err}), 32'd0);

    // Edge on the last WAIT cycle wins
    push_entry(0, 1, 2, 2);
    start = 1'b1; cyc("s"); cyc("w");
    for (int k = 1; k < TO; k++) cyc("w");
    cmd_done = 1'b1; cyc("late_edge");
    chk("late_edge_noerr", 32'({busy, timeout_err}), 32'd0);
    cmd_done = 1'b0; cyc("w");

    // cmd_done already high at issue
    push_entry(1, 0, 0, 0);
    cmd_done = 1'b1; cyc("hi_idle");
    start = 1'b1; cyc("s"); cyc("w"); cyc("w"); cyc("w");
    chk("hi_at_issue_busy", 32'(busy), 32'd1);
    cmd_done = 1'b0; cyc("w");
    cmd_done = 1'b1; cyc("rise");
    chk("hi_at_issue_done", 32'(busy), 32'd0);
    cmd_done = 1'b0; cyc("w");

    // cmd_done rising during ISSUE
    push_entry(0, 0, 1, 1);
    start = 1'b1; cyc("s");
    cmd_done = 1'b1; cyc("rise_issue"); cyc("w"); cyc("w");
    chk("rise_issue_busy", 32'(busy), 32'd1);
    cmd_done = 1'b0; cyc("w");
    cmd_done = 1'b1; cyc("rise2");
    chk("rise_issue_done", 32'(busy), 32'd0);
    cmd_done = 1'b0; cyc("w");

    // Abort mid-WAIT with 3 queued
    for (int i = 0; i < 4; i++) push_entry(0, 0, 3, 2);
    start = 1'b1; cyc("s"); cyc("w"); cyc("w");
    chk("abort_pre_count", 32'(count), 32'd3);
    abort = 1'b1; cyc("abort");
    chk("abort_idle", 32'({busy, count}), 32'd0);
    chk("abort_cmd_held", 32'(cmd), 32'h2BF2);
    for (int k = 0; k < 6; k++) begin
      cmd_done = ~cmd_done; cyc("post_abort");
      chk("post_abort_send", 32'(send_cmd), 32'd0);
    end
    cmd_done = 1'b0; cyc("w");

    // Reset mid-run
    for (int i = 0; i < 3; i++) push_entry(0, 1, 0, 1);
    start = 1'b1; cyc("s"); cyc("w");
    rst = 1'b1; cyc("rst_mid");
    check_reset_outputs("rst_mid");
    for (int k = 0; k < 4; k++) begin
      cmd_done = ~cmd_done; cyc("post_rst");
      chk("post_rst_send", 32'(send_cmd), 32'd0);
    end
    cmd_done = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      enq         = ($urandom_range(0, 99) < 40);
      enq_cal     = ($urandom_range(0, 9) < 2);
      enq_fanfare = 1'($urandom);
      enq_dir     = 2'($urandom_range(0, 3));
      enq_sqrs    = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      start       = ($urandom_range(0, 99) < 15);
      abort       = ($urandom_range(0, 999) < 15);
      clr_err     = ($urandom_range(0, 99) < 20);
      rst         = ($urandom_range(0, 999) < 4);
      if ($urandom_range(0, 99) < 20) cmd_done = ~cmd_done;
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
